// File: rtl/iot_event_encoder_pkg.sv
// iot_pkg: shared sizes, device index type and event-direction constants for the iot event encoder
package iot_pkg;
  localparam int IOT_NDEV_DEFAULT = 8;
  localparam int IOT_CNT_W = 8;
  typedef logic [$clog2(IOT_NDEV_DEFAULT)-1:0] dev_idx_t;
  localparam logic EV_OFF = 1'b0;
  localparam logic EV_ON = 1'b1;
endpackage

// File: rtl/iot_event_encoder_rr_pick.sv
// rr_pick: combinational round-robin first-set-bit finder over req starting at ptr, wrapping at N
module rr_pick #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);
  assign valid = |req;
  always_comb begin
    int p;
    p = 0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = (int'(ptr) + k) % N;
      idx = req[p] ? IW'(p) : idx;
    end
  end
endmodule

// File: rtl/iot_event_encoder.sv
// iot_event_encoder: reports per-device on/off transitions as round-robin change pulses (IOT_DEBOUNCE_EN adds per-device debounce)
module iot_event_encoder
  import iot_pkg::*;
#(
  parameter int N_DEV = IOT_NDEV_DEFAULT,
  parameter int CNT_W = IOT_CNT_W,
  parameter int DEB_CYCLES = 4,
  localparam int IW = $clog2(N_DEV),
  localparam int PW = $clog2(N_DEV + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_status,
  input  logic             hold,
  output logic             change,
  output logic             on_off,
  output logic [IW-1:0]    dev_id,
  output logic [PW-1:0]    pending,
  output logic [CNT_W-1:0] active_count
);
  logic [N_DEV-1:0] status_q;
  logic [N_DEV-1:0] reported;
  logic [N_DEV-1:0] diff;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic pick_valid;
`ifdef IOT_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  for (genvar i = 0; i < N_DEV; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic q;
    always_ff @(posedge clk)
      if (rst) begin
        cnt <= '0;
        q <= 1'b0;
      end else if (dev_status[i] == q) cnt <= '0;
      else if (cnt == DW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        q <= dev_status[i];
      end else cnt <= cnt + DW'(1);
    assign status_q[i] = q;
  end
`else
  always_ff @(posedge clk) status_q <= rst ? '0 : dev_status;
`endif
  assign diff = status_q ^ reported;
  rr_pick #(.N(N_DEV)) u_pick (
    .req  (diff),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .idx  (pick)
  );
  always_ff @(posedge clk)
    if (rst) begin
      change <= 1'b0;
      on_off <= 1'b0;
      dev_id <= '0;
      pending <= '0;
      active_count <= '0;
      reported <= '0;
      rr_ptr <= '0;
    end else begin
      pending <= PW'($countones(diff));
      if (!hold && pick_valid) begin
        change <= 1'b1;
        on_off <= status_q[pick];
        dev_id <= pick;
        reported[pick] <= status_q[pick];
        rr_ptr <= pick == IW'(N_DEV - 1) ? '0 : pick + IW'(1);
        active_count <= status_q[pick] == EV_ON ? active_count + CNT_W'(1) : active_count - CNT_W'(1);
      end else begin
        change <= 1'b0;
        on_off <= 1'b0;
      end
    end
endmodule
